// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master bus arbiter with registered grants and a master-side mux.
//   Master 0 has default priority and the bus always parks on a master.
//   Optional build macro ARB_STARVE_GUARD_EN adds a hold counter. With the counter,
//   a continuously contested owner is forced to hand over after MAX_HOLD+1 cycles.
// Ports:
//   clk, reset_n            - clock, asynchronous active-low reset
//   M0_req, M1_req          - bus requests
//   M0_/M1_addr, _wr, _dout - master transaction signals
//   M0_grant, M1_grant      - one-hot registered ownership
//   S_addr, S_wr, S_din     - owner's signals steered to the slave side
//   arb_switch              - pulse in the first cycle after an ownership change
module bus_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              M0_req,
  input  logic              M1_req,
  input  logic [ADDR_W-1:0] M0_addr,
  input  logic [ADDR_W-1:0] M1_addr,
  input  logic              M0_wr,
  input  logic              M1_wr,
  input  logic [DATA_W-1:0] M0_dout,
  input  logic [DATA_W-1:0] M1_dout,
  output logic              M0_grant,
  output logic              M1_grant,
  output logic [ADDR_W-1:0] S_addr,
  output logic              S_wr,
  output logic [DATA_W-1:0] S_din,
  output logic              arb_switch
);
  typedef enum logic {M0_GRANT = 1'b0, M1_GRANT = 1'b1} state_t;
  state_t state_q, state_d;
  logic   switch_q;
  logic   expire;
`ifdef ARB_STARVE_GUARD_EN
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              contested;
  // Both requests high means the owner and the other master are both asking.
  assign contested = M0_req & M1_req;
  assign expire    = contested && (hold_q == HOLD_W'(MAX_HOLD));
  always_comb begin
    hold_d = hold_q;
    hold_d = (state_d != state_q || !contested) ? '0 : (&hold_q ? hold_q : hold_q + 1'b1);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) hold_q <= '0;
    else          hold_q <= hold_d;
`else
  logic [HOLD_W-1:0] unused_hold;
  assign unused_hold = HOLD_W'(MAX_HOLD);
  assign expire      = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    state_d = (state_q == M0_GRANT) ? (((!M0_req && M1_req) || expire) ? M1_GRANT : M0_GRANT)
                                    : ((!M1_req || expire) ? M0_GRANT : M1_GRANT);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q  <= M0_GRANT;
      switch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      switch_q <= (state_d != state_q);
    end
  assign M0_grant   = (state_q == M0_GRANT);
  assign M1_grant   = (state_q == M1_GRANT);
  assign arb_switch = switch_q;
  assign S_addr     = M1_grant ? M1_addr : M0_addr;
  assign S_wr       = M1_grant ? M1_wr   : M0_wr;
  assign S_din      = M1_grant ? M1_dout : M0_dout;
endmodule
